mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb.sv | 116 +++++++++++
 tb/tb_mem_arb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// response-owner encoding and the fixed byte mask used for fetches.
package mem_arb_pkg;

  // Who the pending read response belongs to.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  // Fetches always read the low four byte lanes.
  localparam logic [7:0] FETCH_WMASK = 8'h0F;

endpackage

// File: rtl/mem_arb.sv
// Two-requester arbiter sharing one memory port between instruction fetch (I)
// and data access (D). D normally wins; a starvation counter guarantees that I
// gets through after STARVE_LIMIT consecutive D grants. Reads return one cycle
// after the grant and are routed back using a one-entry owner register.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  // data side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [7:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // shared memory port
  output logic        m_valid,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [7:0]  m_wmask,
  input  logic [31:0] m_rdata
);

  // Counter just wide enough to hold STARVE_LIMIT.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  owner_e        owner_reg;
  owner_e        owner_next;
  logic          starved;

  // Grant decision: purely from requests and registered state, never from rvalid.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    starved = (cnt_reg == LIMIT);
    if (!rst) begin
      if (d_req && !(i_req && starved)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Memory port mux: forward the winner, all zeros when idle.
  always_comb begin
    m_valid = 1'b0;
    m_wen   = 1'b0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    m_wmask = 8'd0;
    if (d_gnt) begin
      m_valid = 1'b1;
      m_wen   = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end else if (i_gnt) begin
      m_valid = 1'b1;
      m_addr  = i_addr;
      m_wmask = FETCH_WMASK;
    end
  end

  // Next-state for the starvation counter and response owner.
  always_comb begin
    cnt_next   = cnt_reg;
    owner_next = OWNER_NONE;
    if (!i_req || i_gnt) begin
      cnt_next = '0;
    end else if (d_gnt && (cnt_reg != LIMIT)) begin
      cnt_next = cnt_reg + CW'(1);
    end
    // Stores finish in their grant cycle, so only reads leave an owner behind.
    if (i_gnt) begin
      owner_next = OWNER_I;
    end else if (d_gnt && !d_we) begin
      owner_next = OWNER_D;
    end
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      owner_reg <= OWNER_NONE;
    end else begin
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
    end
  end

  // Response routing: owner sees m_rdata for one cycle, the other side sees 0.
  always_comb begin
    i_rvalid = !rst && (owner_reg == OWNER_I);
    d_rvalid = !rst && (owner_reg == OWNER_D);
    i_rdata  = i_rvalid ? m_rdata : 32'd0;
    d_rdata  = d_rvalid ? m_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: grant/port checks per cycle, read responses
// checked against a scoreboard of expected (owner, data, due cycle) entries.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_valid, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic [31:0] m_rdata = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    owner_e      owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rdata(m_rdata)
  );

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0073;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && !m_wen) m_rdata <= mem_f(m_addr);
  end

  // Response monitor: every cycle the rvalid/rdata pair must match the scoreboard.
  always @(negedge clk) begin
    logic        e_irv, e_drv;
    logic [31:0] e_ird, e_drd;
    exp_t        e;
    e_irv = 1'b0; e_drv = 1'b0; e_ird = 32'd0; e_drd = 32'd0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      e_irv = (e.owner == OWNER_I);
      e_drv = (e.owner == OWNER_D);
      e_ird = e_irv ? e.data : 32'd0;
      e_drd = e_drv ? e.data : 32'd0;
    end
    checks++;
    assert ({i_rvalid, d_rvalid, i_rdata, d_rdata} === {e_irv, e_drv, e_ird, e_drd})
    else begin
      errors++;
      $error("FAIL resp cyc%0d: irv=%b drv=%b ird=%h drd=%h, expected irv=%b drv=%b ird=%h drd=%h",
             cyc, i_rvalid, d_rvalid, i_rdata, d_rdata, e_irv, e_drv, e_ird, e_drd);
    end
    $display("cyc %0d: i_gnt=%b d_gnt=%b m_valid=%b m_addr=%h i_rvalid=%b d_rvalid=%b",
             cyc, i_gnt, d_gnt, m_valid, m_addr, i_rvalid, d_rvalid);
  end

  // One cycle: check grants and memory port at negedge, optionally push a response.
  task automatic cycle_check(input string tag, input logic e_ig, input logic e_dg,
                             input logic [31:0] e_addr, input logic e_wen,
                             input logic [31:0] e_wdata, input logic [7:0] e_mask,
                             input logic do_push, input owner_e p_owner,
                             input logic [31:0] p_data);
    exp_t e;
    @(negedge clk);
    checks++;
    assert ({i_gnt, d_gnt, m_valid, m_wen, m_addr, m_wdata, m_wmask} ===
            {e_ig, e_dg, (e_ig | e_dg), e_wen, e_addr, e_wdata, e_mask})
    else begin
      errors++;
      $error("FAIL %s: ig=%b dg=%b mv=%b wen=%b addr=%h wd=%h mask=%h, expected ig=%b dg=%b wen=%b addr=%h wd=%h mask=%h",
             tag, i_gnt, d_gnt, m_valid, m_wen, m_addr, m_wdata, m_wmask,
             e_ig, e_dg, e_wen, e_addr, e_wdata, e_mask);
    end
    if (do_push) begin
      e.owner = p_owner; e.data = p_data; e.due = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle(input string tag);
    cycle_check(tag, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0, OWNER_NONE, 32'd0);
  endtask

  task automatic exp_fetch(input string tag, input logic [31:0] a);
    cycle_check(tag, 1'b1, 1'b0, a, 1'b0, 32'd0, 8'h0F, 1'b1, OWNER_I, mem_f(a));
  endtask

  task automatic exp_dload(input string tag, input logic [31:0] a, input logic [7:0] mask,
                           input logic [31:0] wd, input logic push);
    cycle_check(tag, 1'b0, 1'b1, a, 1'b0, wd, mask, push, OWNER_D, mem_f(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  starve_pat;
    logic [31:0] ia, da;
    rst = 1'b1; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_wmask = 8'd0;
    @(posedge clk); #1;

    // Reset: requests present but nothing may be granted.
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h50;
    exp_idle("reset_gate0");
    exp_idle("reset_gate1");
    checks++;
    assert (dut.owner_reg === OWNER_NONE)
    else begin
      errors++;
      $error("FAIL reset_owner: got %0d, expected %0d", dut.owner_reg, OWNER_NONE);
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    exp_idle("idle_after_reset");

    // Lone fetch.
    i_req = 1'b1; i_addr = 32'h8000_0000;
    exp_fetch("lone_fetch", 32'h8000_0000);
    i_req = 1'b0;
    exp_idle("lone_fetch_resp");

    // Simultaneous: D wins first, I next cycle.
    i_req = 1'b1; i_addr = 32'h8000_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_1000; d_wmask = 8'h0F;
    exp_dload("simul_d", 32'h8000_1000, 8'h0F, 32'd0, 1'b1);
    d_req = 1'b0; d_addr = 32'd0; d_wmask = 8'd0;
    exp_fetch("simul_i", 32'h8000_0004);
    i_req = 1'b0;
    exp_idle("simul_tail");

    // Starvation: I wins at cycles 4 and 9 with both held high.
    starve_pat = 10'b10_0001_0000;
    ia = 32'h100; da = 32'h200;
    i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da; d_wmask = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      if (starve_pat[k]) begin
        exp_fetch($sformatf("starve_i%0d", k), ia);
        ia = ia + 32'd4; i_addr = ia;
      end else begin
        exp_dload($sformatf("starve_d%0d", k), da, 8'hFF, 32'd0, 1'b1);
        da = da + 32'd4; d_addr = da;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_addr = 32'd0; d_wmask = 8'd0;
    exp_idle("starve_tail");

    // Store: written in grant cycle, no response afterwards.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_2000; d_wdata = 32'hDEAD_BEEF; d_wmask = 8'h03;
    cycle_check("store", 1'b0, 1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 8'h03,
                1'b0, OWNER_NONE, 32'd0);
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wmask = 8'd0;
    exp_idle("store_no_resp");

    // Reset right after a load grant: the response is discarded.
    d_req = 1'b1; d_addr = 32'h8000_3000; d_wmask = 8'h0F;
    exp_dload("rst_mid_load", 32'h8000_3000, 8'h0F, 32'd0, 1'b0);
    d_req = 1'b0; d_addr = 32'd0; d_wmask = 8'd0; rst = 1'b1;
    exp_idle("rst_mid_hold");
    checks++;
    assert (dut.owner_reg === OWNER_NONE)
    else begin
      errors++;
      $error("FAIL rst_mid_owner: got %0d, expected %0d", dut.owner_reg, OWNER_NONE);
    end
    rst = 1'b0;
    exp_idle("rst_mid_after");

    // Back-to-back fetches.
    i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr = 32'(k * 4);
      exp_fetch($sformatf("b2b_%0d", k), 32'(k * 4));
    end
    i_req = 1'b0; i_addr = 32'd0;
    exp_idle("b2b_tail0");
    exp_idle("b2b_tail1");

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
